// File: rtl/mux_rr_chan.sv
// mux_rr_chan: registered CHANNELS-to-1 multiplexer with per-channel valid/ready handshake.
// Several producers share one WIDTH-bit bus into the ALU operand path. A grant is chosen
// combinationally by round-robin, fixed priority or external select. The granted word is
// captured in a one-deep output register.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_bus     channel i data at in_bus[i*WIDTH +: WIDTH]
//   in_valid   channel i offers a word
//   in_ready   channel i word accepted this cycle (one-hot or zero)
//   ext_sel    channel to serve when MODE==2, ignored otherwise
//   out        registered selected word
//   out_chan   index of the channel that supplied out
//   out_valid  out/out_chan hold a word
//   out_ready  consumer accepts out this cycle
module mux_rr_chan #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned SEL_LENGTH = 2,
    parameter int unsigned MODE       = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_bus,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_LENGTH-1:0]     ext_sel,
    output logic [WIDTH-1:0]          out,
    output logic [SEL_LENGTH-1:0]     out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      out_q;
    logic [SEL_LENGTH-1:0] out_chan_q;
    logic [SEL_LENGTH-1:0] rr_ptr_q;

    logic                  grant_any;
    logic [SEL_LENGTH-1:0] grant_idx;
    logic [CHANNELS-1:0]   grant_oh;
    logic [WIDTH-1:0]      sel_data;
    logic [SEL_LENGTH-1:0] rr_next;
    logic                  load;

    // Grant selection. Round-robin uses two passes: first the channels at or above the
    // pointer, then all channels, so the search wraps CHANNELS-1 -> 0.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        unique case (MODE)
            0: begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (!grant_any && in_valid[i] && (SEL_LENGTH'(i) >= rr_ptr_q)) begin
                        grant_any = 1'b1;
                        grant_idx = SEL_LENGTH'(i);
                    end
                end
                for (int i = 0; i < CHANNELS; i++) begin
                    if (!grant_any && in_valid[i]) begin
                        grant_any = 1'b1;
                        grant_idx = SEL_LENGTH'(i);
                    end
                end
            end
            1: begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (!grant_any && in_valid[i]) begin
                        grant_any = 1'b1;
                        grant_idx = SEL_LENGTH'(i);
                    end
                end
            end
            default: begin
                // An ext_sel beyond the last channel matches no i and so grants nothing.
                for (int i = 0; i < CHANNELS; i++) begin
                    if (in_valid[i] && (SEL_LENGTH'(i) == ext_sel)) begin
                        grant_any = 1'b1;
                        grant_idx = SEL_LENGTH'(i);
                    end
                end
            end
        endcase
    end

    // One-hot form of the grant drives both in_ready and the data mux.
    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            grant_oh[i] = grant_any && (grant_idx == SEL_LENGTH'(i));
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_oh[i]) begin
                sel_data = sel_data | in_bus[i*WIDTH +: WIDTH];
            end
        end
    end

    // A load may overlap a drain, so a FULL register refills with no bubble.
    assign load     = !rst && (!out_valid || out_ready) && grant_any;
    assign in_ready = load ? grant_oh : '0;
    assign rr_next  = (grant_idx == SEL_LENGTH'(CHANNELS - 1)) ? '0
                                                               : grant_idx + SEL_LENGTH'(1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: begin
                if (load) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                if (load) begin
                    state_d = StFull;
                end else if (out_ready) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // out and out_chan keep their last value after a drain; only a load rewrites them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q      <= '0;
            out_chan_q <= '0;
            rr_ptr_q   <= '0;
        end else if (load) begin
            out_q      <= sel_data;
            out_chan_q <= grant_idx;
            if (MODE == 0) begin
                rr_ptr_q <= rr_next;
            end
        end
    end

    assign out       = out_q;
    assign out_chan  = out_chan_q;
    assign out_valid = (state_q == StFull);

endmodule

// File: tb/tb_mux_rr_chan.sv
// Testbench for mux_rr_chan: three instances (round-robin, fixed priority, external
// select) share one stimulus. A queue-free array model predicts every output each cycle;
// directed literal checks pin the model to hand-computed values.
module tb_mux_rr_chan;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam int SL = 2;

    logic            clk;
    logic            rst;
    logic [CH*W-1:0] in_bus;
    logic [CH-1:0]   in_valid;
    logic [SL-1:0]   ext_sel;
    logic            out_ready;

    logic [CH-1:0]   in_ready_w  [3];
    logic [W-1:0]    out_w       [3];
    logic [SL-1:0]   out_chan_w  [3];
    logic            out_valid_w [3];

    int checks = 0;
    int errors = 0;

    // Model state per instance (index = MODE).
    logic       m_valid [3];
    logic [7:0] m_out   [3];
    int         m_chan  [3];
    int         m_rr    [3];

    mux_rr_chan #(.WIDTH(W), .CHANNELS(CH), .SEL_LENGTH(SL), .MODE(0)) u_rr (
        .clk(clk), .rst(rst), .in_bus(in_bus), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .ext_sel(ext_sel), .out(out_w[0]), .out_chan(out_chan_w[0]),
        .out_valid(out_valid_w[0]), .out_ready(out_ready)
    );
    mux_rr_chan #(.WIDTH(W), .CHANNELS(CH), .SEL_LENGTH(SL), .MODE(1)) u_fp (
        .clk(clk), .rst(rst), .in_bus(in_bus), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .ext_sel(ext_sel), .out(out_w[1]), .out_chan(out_chan_w[1]),
        .out_valid(out_valid_w[1]), .out_ready(out_ready)
    );
    mux_rr_chan #(.WIDTH(W), .CHANNELS(CH), .SEL_LENGTH(SL), .MODE(2)) u_ext (
        .clk(clk), .rst(rst), .in_bus(in_bus), .in_valid(in_valid), .in_ready(in_ready_w[2]),
        .ext_sel(ext_sel), .out(out_w[2]), .out_chan(out_chan_w[2]),
        .out_valid(out_valid_w[2]), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Granted channel for a mode, or -1 when nothing is granted.
    function automatic int model_grant(input int mode, input int rr);
        if (mode == 0) begin
            for (int k = 0; k < CH; k++) begin
                if (in_valid[(rr + k) % CH]) return (rr + k) % CH;
            end
        end else if (mode == 1) begin
            for (int c = 0; c < CH; c++) begin
                if (in_valid[c]) return c;
            end
        end else begin
            if (int'(ext_sel) < CH && in_valid[ext_sel]) return int'(ext_sel);
        end
        return -1;
    endfunction

    function automatic logic [7:0] chan_data(input int c);
        logic [CH*W-1:0] bus;
        bus = in_bus;
        return bus[c*W +: W];
    endfunction

    // Inputs change only just after posedge, so at negedge they are what the next edge sees.
    always @(negedge clk) begin
        for (int m = 0; m < 3; m++) begin
            int g;
            logic [3:0] exp_ready;
            logic accept;
            if (rst) begin
                m_valid[m] = 1'b0;
                m_out[m]   = 8'h00;
                m_chan[m]  = 0;
                m_rr[m]    = 0;
            end
            g = model_grant(m, m_rr[m]);
            accept = !rst && (!m_valid[m] || out_ready) && (g >= 0);
            exp_ready = accept ? 4'(1 << g) : 4'b0000;
            check($sformatf("cyc_valid_m%0d", m), 32'(out_valid_w[m]), 32'(m_valid[m]));
            check($sformatf("cyc_out_m%0d", m), 32'(out_w[m]), 32'(m_out[m]));
            check($sformatf("cyc_chan_m%0d", m), 32'(out_chan_w[m]), 32'(m_chan[m]));
            check($sformatf("cyc_ready_m%0d", m), 32'(in_ready_w[m]), 32'(exp_ready));
            if (!rst) begin
                if (accept) begin
                    m_valid[m] = 1'b1;
                    m_out[m]   = chan_data(g);
                    m_chan[m]  = g;
                    if (m == 0) m_rr[m] = (g + 1) % CH;
                end else if (m_valid[m] && out_ready) begin
                    m_valid[m] = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input int m, input logic v,
                              input logic [7:0] d, input int c);
        check({name, "_valid"}, 32'(out_valid_w[m]), 32'(v));
        check({name, "_out"}, 32'(out_w[m]), 32'(d));
        check({name, "_chan"}, 32'(out_chan_w[m]), 32'(c));
    endtask

    initial begin
        logic [7:0] t2_data [5];
        int         t2_chan [5];
        t2_data = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
        t2_chan = '{0, 1, 2, 3, 0};

        rst       = 1'b1;
        in_bus    = {8'h43, 8'h32, 8'h21, 8'h10};
        in_valid  = 4'b0000;
        ext_sel   = 2'd0;
        out_ready = 1'b1;
        step();
        step();
        expect_out("reset", 0, 1'b0, 8'h00, 0);
        check("reset_ready", 32'(in_ready_w[0]), 32'h0);
        rst = 1'b0;

        // Round-robin over all four channels, one word per cycle.
        in_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_out($sformatf("rr_seq%0d", i), 0, 1'b1, t2_data[i], t2_chan[i]);
            expect_out($sformatf("fp_seq%0d", i), 1, 1'b1, 8'h10, 0);
        end

        // Back-pressure while 0x21 is held.
        step();
        expect_out("bp_load", 0, 1'b1, 8'h21, 1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out($sformatf("bp_hold%0d", i), 0, 1'b1, 8'h21, 1);
            check($sformatf("bp_ready%0d", i), 32'(in_ready_w[0]), 32'h0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready_w[0]), 32'h4);
        step();
        expect_out("bp_next", 0, 1'b1, 8'h32, 2);

        // Pointer now 3; channels 0 and 2 only: wrap to ch0, then ch2.
        in_valid = 4'b0101;
        step();
        expect_out("wrap0", 0, 1'b1, 8'h10, 0);
        step();
        expect_out("wrap2", 0, 1'b1, 8'h32, 2);

        // Fixed priority: ch1 beats ch3 until ch1 drops.
        in_valid = 4'b1010;
        step();
        expect_out("fp_ch1a", 1, 1'b1, 8'h21, 1);
        step();
        expect_out("fp_ch1b", 1, 1'b1, 8'h21, 1);
        in_valid = 4'b1000;
        step();
        expect_out("fp_ch3", 1, 1'b1, 8'h43, 3);

        // External select.
        ext_sel  = 2'd2;
        in_valid = 4'b0100;
        in_bus   = {8'h43, 8'h5A, 8'h21, 8'h10};
        step();
        expect_out("ext_sel2", 2, 1'b1, 8'h5A, 2);
        ext_sel  = 2'd3;
        in_valid = 4'b0000;
        step();
        expect_out("ext_drain", 2, 1'b0, 8'h5A, 2);

        // ext_sel changes while stalled take effect only at the next load.
        in_bus   = {8'h43, 8'h32, 8'h21, 8'h10};
        in_valid = 4'b1111;
        ext_sel  = 2'd1;
        step();
        expect_out("ext_ch1", 2, 1'b1, 8'h21, 1);
        out_ready = 1'b0;
        ext_sel   = 2'd3;
        step();
        expect_out("ext_stall", 2, 1'b1, 8'h21, 1);
        out_ready = 1'b1;
        step();
        expect_out("ext_ch3", 2, 1'b1, 8'h43, 3);

        // Asynchronous reset mid-stream clears immediately.
        #2;
        rst = 1'b1;
        #1;
        expect_out("async_rst", 0, 1'b0, 8'h00, 0);
        check("async_rst_ready", 32'(in_ready_w[0]), 32'h0);
        step();
        rst = 1'b0;
        step();
        expect_out("post_rst", 0, 1'b1, 8'h10, 0);
        step();
        expect_out("post_rst2", 0, 1'b1, 8'h21, 1);
        in_valid = 4'b0000;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
